// File: rtl/vend_pkg.sv
// Shared types for the vending transaction sequencer: FSM states, coin and error codes.
// The optional inactivity timeout is enabled with VEND_TIMEOUT_EN (see vend_controller).
package vend_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_COLLECT  = 3'd1,
        ST_PRICE    = 3'd2,
        ST_DISPENSE = 3'd3,
        ST_CHANGE   = 3'd4
    } state_t;

    localparam logic [1:0] COIN_5  = 2'b00;
    localparam logic [1:0] COIN_10 = 2'b01;
    localparam logic [1:0] COIN_20 = 2'b10;
    localparam logic [1:0] COIN_50 = 2'b11;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_STOCK    = 2'b01;
    localparam logic [1:0] ERR_CREDIT   = 2'b10;
    localparam logic [1:0] ERR_OVERFLOW = 2'b11;

    // Credit units are multiples of 100 currency units (500 -> 5).
    function automatic logic [7:0] coin_value(input logic [1:0] code);
        case (code)
            COIN_5:  coin_value = 8'd5;
            COIN_10: coin_value = 8'd10;
            COIN_20: coin_value = 8'd20;
            default: coin_value = 8'd50;
        endcase
    endfunction

endpackage

// File: rtl/change_selector.sv
// Greedy change picker: largest coin not exceeding the remaining credit.
module change_selector
    import vend_pkg::*;
#(
    parameter int CREDIT_W = 16
) (
    input  logic [CREDIT_W-1:0] credit_i,
    output logic [1:0]          coin_o,
    output logic [CREDIT_W-1:0] value_o
);

    logic [1:0] pick;

    always_comb begin
        pick = COIN_5;
        if (credit_i >= CREDIT_W'(50))
            pick = COIN_50;
        else if (credit_i >= CREDIT_W'(20))
            pick = COIN_20;
        else if (credit_i >= CREDIT_W'(10))
            pick = COIN_10;
    end

    assign coin_o  = pick;
    assign value_o = CREDIT_W'(coin_value(pick));

endmodule

// File: rtl/vend_controller.sv
// Vending transaction sequencer: credit collection, price query, dispense and change return.
// Define VEND_TIMEOUT_EN to refund credit after TIMEOUT_CYCLES of inactivity in COLLECT.
module vend_controller
    import vend_pkg::*;
#(
    parameter int CREDIT_W       = 16,
    parameter int MAX_CREDIT     = 200,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                coin_valid,
    input  logic [1:0]          coin,
    input  logic                select_valid,
    input  logic [2:0]          product_id,
    input  logic                cancel,
    output logic                price_req,
    output logic [2:0]          price_id,
    input  logic                price_ack,
    input  logic [7:0]          price,
    input  logic                stock_ok,
    output logic                dispense,
    output logic                change_valid,
    output logic [1:0]          change_coin,
    input  logic                change_ready,
    output logic                coin_reject,
    output logic                err_valid,
    output logic [1:0]          err_code,
    output logic [CREDIT_W-1:0] credit,
    output logic [2:0]          state
);

    state_t              state_q;
    logic [CREDIT_W-1:0] credit_q;
    logic [2:0]          price_id_q;
    logic                price_req_q, dispense_q, change_valid_q;
    logic [1:0]          change_coin_q;
    logic                coin_reject_q, err_valid_q;
    logic [1:0]          err_code_q;

    logic [CREDIT_W-1:0] credit_plus_d, price_ext_d, chg_value_d, sel_value_d;
    logic [1:0]          sel_coin_d;

    assign credit_plus_d = credit_q + CREDIT_W'(coin_value(coin));
    assign price_ext_d   = CREDIT_W'(price);
    assign chg_value_d   = CREDIT_W'(coin_value(change_coin_q));

    change_selector #(.CREDIT_W(CREDIT_W)) u_change_selector (
        .credit_i (credit_q),
        .coin_o   (sel_coin_d),
        .value_o  (sel_value_d)
    );

`ifdef VEND_TIMEOUT_EN
    logic [15:0] idle_cnt_q;
    logic        timeout_d;
    assign timeout_d = (idle_cnt_q == 16'(TIMEOUT_CYCLES - 1)) && !coin_valid;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    logic [CREDIT_W-1:0] unused_sel_value;
    assign unused_sel_value = sel_value_d;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            credit_q       <= '0;
            price_id_q     <= '0;
            price_req_q    <= 1'b0;
            dispense_q     <= 1'b0;
            change_valid_q <= 1'b0;
            change_coin_q  <= COIN_5;
            coin_reject_q  <= 1'b0;
            err_valid_q    <= 1'b0;
            err_code_q     <= ERR_NONE;
`ifdef VEND_TIMEOUT_EN
            idle_cnt_q     <= '0;
`endif
        end else begin
            dispense_q    <= 1'b0;
            coin_reject_q <= 1'b0;
            err_valid_q   <= 1'b0;
`ifdef VEND_TIMEOUT_EN
            // Counter idles at zero outside COLLECT, so entry always starts a fresh window.
            if (state_q == ST_COLLECT && !coin_valid && !select_valid)
                idle_cnt_q <= idle_cnt_q + 16'd1;
            else
                idle_cnt_q <= '0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (coin_valid) begin
                        credit_q <= credit_plus_d;
                        state_q  <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (coin_valid) begin
                        if (credit_plus_d > CREDIT_W'(MAX_CREDIT)) begin
                            coin_reject_q <= 1'b1;
                            err_valid_q   <= 1'b1;
                            err_code_q    <= ERR_OVERFLOW;
                        end else begin
                            credit_q <= credit_plus_d;
                        end
                    end
                    if (cancel) begin
                        state_q <= ST_CHANGE;
                    end else if (select_valid) begin
                        price_id_q  <= product_id;
                        price_req_q <= 1'b1;
                        state_q     <= ST_PRICE;
                    end
`ifdef VEND_TIMEOUT_EN
                    else if (timeout_d) begin
                        state_q <= ST_CHANGE;
                    end
`endif
                end
                ST_PRICE: begin
                    coin_reject_q <= coin_valid;
                    if (price_req_q && price_ack) begin
                        price_req_q <= 1'b0;
                        if (!stock_ok) begin
                            err_valid_q <= 1'b1;
                            err_code_q  <= ERR_STOCK;
                            state_q     <= ST_COLLECT;
                        end else if (price_ext_d > credit_q) begin
                            err_valid_q <= 1'b1;
                            err_code_q  <= ERR_CREDIT;
                            state_q     <= ST_COLLECT;
                        end else begin
                            credit_q   <= credit_q - price_ext_d;
                            dispense_q <= 1'b1;
                            state_q    <= ST_DISPENSE;
                        end
                    end
                end
                ST_DISPENSE: begin
                    coin_reject_q <= coin_valid;
                    if (credit_q != '0) begin
                        change_valid_q <= 1'b1;
                        change_coin_q  <= sel_coin_d;
                        state_q        <= ST_CHANGE;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_CHANGE: begin
                    coin_reject_q <= coin_valid;
                    // One idle cycle after each handshake before the next coin is offered.
                    if (change_valid_q) begin
                        if (change_ready) begin
                            change_valid_q <= 1'b0;
                            credit_q       <= credit_q - chg_value_d;
                            if (credit_q == chg_value_d)
                                state_q <= ST_IDLE;
                        end
                    end else if (credit_q == '0) begin
                        state_q <= ST_IDLE;
                    end else begin
                        change_valid_q <= 1'b1;
                        change_coin_q  <= sel_coin_d;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign price_req    = price_req_q;
    assign price_id     = price_id_q;
    assign dispense     = dispense_q;
    assign change_valid = change_valid_q;
    assign change_coin  = change_coin_q;
    assign coin_reject  = coin_reject_q;
    assign err_valid    = err_valid_q;
    assign err_code     = err_code_q;
    assign credit       = credit_q;
    assign state        = state_q;

endmodule

// File: tb/tb_vend_controller.sv
// Self-checking bench for vend_controller; expected change coins go through a scoreboard queue.
module tb_vend_controller;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        coin_valid = 1'b0;
    logic [1:0]  coin = 2'b00;
    logic        select_valid = 1'b0;
    logic [2:0]  product_id = 3'd0;
    logic        cancel = 1'b0;
    logic        price_req;
    logic [2:0]  price_id;
    logic        price_ack = 1'b0;
    logic [7:0]  price = 8'd0;
    logic        stock_ok = 1'b0;
    logic        dispense;
    logic        change_valid;
    logic [1:0]  change_coin;
    logic        change_ready = 1'b0;
    logic        coin_reject;
    logic        err_valid;
    logic [1:0]  err_code;
    logic [15:0] credit;
    logic [2:0]  state;

    int tests_run = 0;
    int tests_failed = 0;
    logic [1:0] exp_q[$];

    vend_controller #(.CREDIT_W(16), .MAX_CREDIT(200), .TIMEOUT_CYCLES(8)) dut (
        .clock(clock), .reset(reset), .coin_valid(coin_valid), .coin(coin),
        .select_valid(select_valid), .product_id(product_id), .cancel(cancel),
        .price_req(price_req), .price_id(price_id), .price_ack(price_ack),
        .price(price), .stock_ok(stock_ok), .dispense(dispense),
        .change_valid(change_valid), .change_coin(change_coin), .change_ready(change_ready),
        .coin_reject(coin_reject), .err_valid(err_valid), .err_code(err_code),
        .credit(credit), .state(state)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic insert_coin(input logic [1:0] c);
        coin_valid = 1'b1; coin = c;
        tick();
        coin_valid = 1'b0;
    endtask

    task automatic do_select(input logic [2:0] id);
        select_valid = 1'b1; product_id = id;
        tick();
        select_valid = 1'b0;
    endtask

    task automatic do_cancel();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
    endtask

    // Acts as the product manager: waits for the request, answers once.
    task automatic answer_query(input logic [7:0] p, input logic ok);
        int n = 0;
        while (price_req !== 1'b1 && n < 20) begin tick(); n++; end
        tests_run++;
        if (price_req !== 1'b1) begin tests_failed++; $display("FAIL price_req_wait: got %b want 1", price_req); end
        price_ack = 1'b1; price = p; stock_ok = ok;
        tick();
        price_ack = 1'b0;
        tests_run++;
        if (price_req !== 1'b0) begin tests_failed++; $display("FAIL price_req_drop: got %b want 0", price_req); end
    endtask

    task automatic drain_change(input int budget);
        logic [1:0] e;
        change_ready = 1'b1;
        for (int n = 0; n < budget; n++) begin
            if (change_valid === 1'b1) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++; $display("FAIL change_unexpected: got coin %b want none", change_coin);
                end else begin
                    e = exp_q.pop_front();
                    if (change_coin !== e) begin tests_failed++; $display("FAIL change_coin: got %b want %b", change_coin, e); end
                end
            end
            if (state === 3'd0 && exp_q.size() == 0 && change_valid !== 1'b1) break;
            tick();
        end
        tests_run++;
        if (state !== 3'd0 || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL change_drain: got state %0d pending %0d want state 0 pending 0", state, exp_q.size());
        end
        exp_q.delete();
        change_ready = 1'b0;
        tests_run++;
        if (credit !== 16'd0) begin tests_failed++; $display("FAIL change_credit: got %0d want 0", credit); end
    endtask

    task automatic test_reset();
        tick();
        tests_run++;
        if (state !== 3'd0 || credit !== 16'd0 || price_id !== 3'd0 || price_req !== 1'b0 ||
            change_valid !== 1'b0 || dispense !== 1'b0 || err_valid !== 1'b0 ||
            coin_reject !== 1'b0 || err_code !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_values: got state %0d credit %0d pid %0d req %b cv %b disp %b ev %b rej %b ec %b want all 0",
                     state, credit, price_id, price_req, change_valid, dispense, err_valid, coin_reject, err_code);
        end
        @(negedge clock);
        reset = 1'b0;
        tick();
    endtask

    task automatic test_purchase();
        insert_coin(2'b00); insert_coin(2'b00); insert_coin(2'b01);
        insert_coin(2'b10); insert_coin(2'b11);
        tests_run++;
        if (credit !== 16'd90 || state !== 3'd1) begin tests_failed++; $display("FAIL purchase_credit: got %0d st %0d want 90 st 1", credit, state); end
        do_select(3'd1);
        tests_run++;
        if (state !== 3'd2 || price_req !== 1'b1 || price_id !== 3'd1) begin
            tests_failed++; $display("FAIL purchase_select: got st %0d req %b id %0d want st 2 req 1 id 1", state, price_req, price_id);
        end
        answer_query(8'd15, 1'b1);
        tests_run++;
        if (dispense !== 1'b1 || credit !== 16'd75 || state !== 3'd3) begin
            tests_failed++; $display("FAIL purchase_dispense: got disp %b credit %0d st %0d want 1 75 3", dispense, credit, state);
        end
        exp_q.push_back(2'b11); exp_q.push_back(2'b10); exp_q.push_back(2'b00);
        tick();
        tests_run++;
        if (dispense !== 1'b0 || change_valid !== 1'b1 || state !== 3'd4) begin
            tests_failed++; $display("FAIL purchase_first_change: got disp %b cv %b st %0d want 0 1 4", dispense, change_valid, state);
        end
        drain_change(40);
    endtask

    task automatic test_insufficient();
        insert_coin(2'b01);
        do_select(3'd2);
        answer_query(8'd25, 1'b1);
        tests_run++;
        if (err_valid !== 1'b1 || err_code !== 2'b10 || state !== 3'd1 || credit !== 16'd10 || dispense !== 1'b0) begin
            tests_failed++; $display("FAIL insufficient_err: got ev %b ec %b st %0d credit %0d disp %b want 1 10 1 10 0",
                                     err_valid, err_code, state, credit, dispense);
        end
        tick();
        tests_run++;
        if (err_valid !== 1'b0 || err_code !== 2'b10) begin tests_failed++; $display("FAIL insufficient_pulse: got ev %b ec %b want 0 10", err_valid, err_code); end
        do_cancel();
        tests_run++;
        if (state !== 3'd4) begin tests_failed++; $display("FAIL cancel_state: got %0d want 4", state); end
        exp_q.push_back(2'b01);
        drain_change(20);
    endtask

    task automatic test_out_of_stock();
        insert_coin(2'b00);
        do_select(3'd3);
        answer_query(8'd3, 1'b0);
        tests_run++;
        if (err_valid !== 1'b1 || err_code !== 2'b01 || dispense !== 1'b0 || state !== 3'd1 || credit !== 16'd5) begin
            tests_failed++; $display("FAIL stock_err: got ev %b ec %b disp %b st %0d credit %0d want 1 01 0 1 5",
                                     err_valid, err_code, dispense, state, credit);
        end
        do_cancel();
        exp_q.push_back(2'b00);
        drain_change(20);
    endtask

    task automatic test_overflow();
        repeat (4) insert_coin(2'b11);
        tests_run++;
        if (credit !== 16'd200 || coin_reject !== 1'b0) begin tests_failed++; $display("FAIL overflow_fill: got %0d rej %b want 200 0", credit, coin_reject); end
        insert_coin(2'b11);
        tests_run++;
        if (coin_reject !== 1'b1 || err_valid !== 1'b1 || err_code !== 2'b11 || credit !== 16'd200) begin
            tests_failed++; $display("FAIL overflow_reject: got rej %b ev %b ec %b credit %0d want 1 1 11 200",
                                     coin_reject, err_valid, err_code, credit);
        end
        do_select(3'd5);
        insert_coin(2'b00);
        tests_run++;
        if (coin_reject !== 1'b1 || err_valid !== 1'b0 || state !== 3'd2 || credit !== 16'd200 || price_req !== 1'b1) begin
            tests_failed++; $display("FAIL price_coin_reject: got rej %b ev %b st %0d credit %0d req %b want 1 0 2 200 1",
                                     coin_reject, err_valid, state, credit, price_req);
        end
        answer_query(8'd200, 1'b1);
        tests_run++;
        if (dispense !== 1'b1 || credit !== 16'd0) begin tests_failed++; $display("FAIL exact_price: got disp %b credit %0d want 1 0", dispense, credit); end
        tick();
        tests_run++;
        if (state !== 3'd0 || change_valid !== 1'b0) begin tests_failed++; $display("FAIL exact_idle: got st %0d cv %b want 0 0", state, change_valid); end
    endtask

    task automatic test_stall_and_reset();
        insert_coin(2'b01);
        do_cancel();
        tick();
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (change_valid !== 1'b1 || change_coin !== 2'b01 || credit !== 16'd10) begin
                tests_failed++; $display("FAIL stall_hold %0d: got cv %b coin %b credit %0d want 1 01 10", i, change_valid, change_coin, credit);
            end
            tick();
        end
        #2 reset = 1'b1;
        #1;
        tests_run++;
        if (state !== 3'd0 || credit !== 16'd0 || change_valid !== 1'b0 || price_id !== 3'd0 || err_code !== 2'b00 || price_req !== 1'b0) begin
            tests_failed++; $display("FAIL async_reset: got st %0d credit %0d cv %b pid %0d ec %b req %b want 0 0 0 0 00 0",
                                     state, credit, change_valid, price_id, err_code, price_req);
        end
        @(negedge clock);
        reset = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        insert_coin(2'b00);
`ifdef VEND_TIMEOUT_EN
        repeat (7) tick();
        tests_run++;
        if (state !== 3'd1) begin tests_failed++; $display("FAIL timeout_early: got st %0d want 1", state); end
        tick();
        tests_run++;
        if (state !== 3'd4 || err_valid !== 1'b0) begin tests_failed++; $display("FAIL timeout_fire: got st %0d ev %b want 4 0", state, err_valid); end
`else
        repeat (300) tick();
        tests_run++;
        if (state !== 3'd1 || credit !== 16'd5) begin tests_failed++; $display("FAIL no_timeout: got st %0d credit %0d want 1 5", state, credit); end
        do_cancel();
`endif
        exp_q.push_back(2'b00);
        drain_change(20);
    endtask

    initial begin
        test_reset();
        test_purchase();
        test_insufficient();
        test_out_of_stock();
        test_overflow();
        test_stall_and_reset();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/vend_controller.md
# vend_controller

Transaction sequencer for the vending machine. It accepts coins into a credit register, takes a product selection, and queries the product manager for price and stock over a request/acknowledge handshake. On a successful check it pulses dispense and deducts the price, then returns change coin by coin through a ready/valid handshake. It sits between the coin input, `product_manager`, and the dispense/change hardware, replacing the free-running `fsm`/`money_counter` pairing.

## Interface
- `CREDIT_W`, 16: credit register width. Units of 100 (500→5, 1000→10, 2000→20, 5000→50).
- `MAX_CREDIT`, 200: largest credit accepted.
- `TIMEOUT_CYCLES`, 255: inactivity limit. Used only with `VEND_TIMEOUT_EN`.
- `clock  in  1`: single clock, rising edge.
- `reset  in  1`: asynchronous, active-high.
- `coin_valid  in  1`: coin present this cycle.
- `coin  in  2`: 00=500, 01=1000, 10=2000, 11=5000.
- `select_valid  in  1`: selection strobe.
- `product_id  in  3`: selected product.
- `cancel  in  1`: abort and refund.
- `price_req  out  1`: price/stock query. Held until `price_ack`.
- `price_id  out  3`: latched product for the query and the dispense.
- `price_ack  in  1`: query answered. `price` and `stock_ok` are valid this cycle.
- `price  in  8`: unit price, credit units.
- `stock_ok  in  1`: stock of `price_id` is greater than 0.
- `dispense  out  1`: one-cycle dispense pulse.
- `change_valid  out  1`: change coin offered.
- `change_coin  out  2`: coin code, same encoding as `coin`.
- `change_ready  in  1`: change coin taken.
- `coin_reject  out  1`: one-cycle pulse. The coin was not credited.
- `err_valid  out  1`: one-cycle error pulse.
- `err_code  out  2`: 01 out of stock, 10 insufficient credit, 11 credit overflow. Holds its last value.
- `credit  out  CREDIT_W`: current credit.
- `state  out  3`: current FSM state.

## Operation
- States: IDLE=0, COLLECT=1, PRICE=2, DISPENSE=3, CHANGE=4.
- IDLE:
  - `coin_valid` → credit += value, go to COLLECT.
  - `select_valid` and `cancel` are ignored.
- COLLECT:
  - `coin_valid` → credit += value.
  - If credit + value > `MAX_CREDIT`: credit unchanged, `coin_reject`=1, `err_valid`=1, `err_code`=11.
  - `select_valid` → latch `product_id` into `price_id`, go to PRICE.
  - `cancel` → go to CHANGE (full refund). It has priority over `select_valid`.
  - A coin in the same cycle as a select is credited. A coin in the same cycle as a cancel is credited, then refunded.
- PRICE:
  - `price_req`=1 until `price_ack`.
  - On `price_ack` with `!stock_ok` → `err_code`=01, go to COLLECT.
  - Otherwise, `price` > credit → `err_code`=10, go to COLLECT.
  - Otherwise credit -= `price`, go to DISPENSE.
  - `cancel` is ignored in this state.
- DISPENSE: `dispense`=1 for one cycle. Go to CHANGE if credit > 0, else IDLE.
- CHANGE:
  - Greedy selection: largest coin ≤ credit (50, 20, 10, 5).
  - `change_valid`=1 with `change_coin` stable until `change_ready`.
  - On handshake, credit -= value. At credit 0, go to IDLE.
  - Credit is always a multiple of 5, so the greedy loop always terminates.
- Any `coin_valid` in PRICE, DISPENSE or CHANGE → `coin_reject`=1 with no error.
- Arithmetic:
  - Credit compare and subtract are unsigned, `CREDIT_W` bits.
  - `price` is zero-extended.
  - An underflow is impossible by construction.

## Timing
- Reset values:
  - `state`=IDLE, credit=0, `price_id`=0.
  - All pulses and `price_req`/`change_valid` = 0.
  - `err_code`=00.
- Reset mid-transaction discards credit and drops handshakes immediately.
- All outputs are registered. Credit updates one cycle after the accepted coin.
- `price_req` rises in the cycle after the select and falls in the cycle after `price_ack`. `price_ack` is sampled only while `price_req`=1.
- `dispense` appears one cycle after the ack. The first `change_valid` appears one cycle after `dispense`.
- One change coin per handshake. A new coin is presented in the cycle after each handshake, so the steady state is one coin per 2 cycles.
- Error and reject pulses occur in the cycle after the causing input.

## Configuration
- `VEND_TIMEOUT_EN` defined:
  - An inactivity counter runs in COLLECT.
  - It clears on `coin_valid`, `select_valid`, or entry to COLLECT.
  - After `TIMEOUT_CYCLES` with no activity → go to CHANGE and refund the credit (no error).
- Undefined: no counter exists, and COLLECT waits indefinitely.

## Structure
- Shared package `vend_pkg`:
  - State enum.
  - Coin code constants and the coin-value function.
  - Error code constants.
- One sub-module, `change_selector`: combinational greedy pick of the next coin code and value from the current credit.

## Test plan
- Coins 00,00,01,10,11 → credit 90. Select id 1, ack with price 15, `stock_ok`=1 → `dispense` pulse, credit 75. Change sequence 11,10,00 with `change_ready` tied high → credit 0, IDLE.
- Credit 10, select, ack with price 25 → `err_code`=10, back to COLLECT, credit 10. Cancel → `change_coin` 01, then IDLE.
- Select with ack `stock_ok`=0 → `err_code`=01, no dispense, credit unchanged.
- Credit 200, coin 11 → `coin_reject`, `err_code`=11, credit stays 200.
- In CHANGE, hold `change_ready`=0 for 5 cycles → `change_valid` and `change_coin` stay stable. Assert reset → all outputs go to their reset values within the same cycle.
- With `VEND_TIMEOUT_EN` and `TIMEOUT_CYCLES`=8: coin 00, then idle → CHANGE entered after 8 cycles, coin 00 returned. Without the macro, still in COLLECT after 300 cycles.
